// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: JZJCoreF pipeline front end.
// Owns the PC, fetches one instruction word at a time from instruction memory,
// holds it for decode and handles branch/jump redirects, including responses
// that were already in flight and are now stale.
// Optional feature macro: JZJCOREF_MISALIGNED_TRAP_EN enables the FAULT state
// and fetchFault for misaligned redirect targets. When the macro is undefined,
// the low two bits of the redirect target are dropped.
module instruction_fetch_unit #(
   parameter logic [31:0] RESET_VECTOR = 32'h00000000
) (
   input  logic        clock,
   input  logic        reset,
   output logic        imemReqValid,
   input  logic        imemReqReady,
   output logic [31:0] imemAddress,
   input  logic        imemRespValid,
   input  logic [31:0] imemRespData,
   output logic        instrValid,
   input  logic        instrReady,
   output logic [31:0] instruction,
   output logic [31:0] pcOfInstruction,
   output logic [31:0] immediateU,
   input  logic        redirectValid,
   input  logic [31:0] redirectTarget,
   output logic        fetchFault
);

   typedef enum logic [2:0] {
      REQUEST   = 3'd0,
      WAIT_RESP = 3'd1,
      HOLD      = 3'd2,
      DRAIN     = 3'd3
`ifdef JZJCOREF_MISALIGNED_TRAP_EN
      ,
      FAULT     = 3'd4
`endif
   } state_t;

   localparam logic [31:0] NOP = 32'h00000013;

   state_t      r_state;
   state_t      w_nextState;
   logic [31:0] r_pc;
   logic [31:0] w_nextPc;
   logic [31:0] r_instruction;
   logic [31:0] r_pcOfInstruction;
   logic        w_latchResp;
   logic        w_outstanding;
   logic [31:0] w_target;

`ifdef JZJCOREF_MISALIGNED_TRAP_EN
   logic        r_fault;
   logic        w_nextFault;
   logic        w_misaligned;

   assign w_target     = redirectTarget;
   assign w_misaligned = |redirectTarget[1:0];
   assign fetchFault   = r_fault;
`else
   logic        w_unusedTargetBits;

   assign w_target           = {redirectTarget[31:2], 2'b00};
   assign w_unusedTargetBits = ^redirectTarget[1:0];
   assign fetchFault         = 1'b0;
`endif

   // A request is only offered from REQUEST, and never while reset is held,
   // even if the state register already reads REQUEST.
   assign imemReqValid    = (r_state == REQUEST) && !reset;
   assign imemAddress     = r_pc;
   assign instrValid      = (r_state == HOLD);
   assign instruction     = r_instruction;
   assign pcOfInstruction = r_pcOfInstruction;
   assign immediateU      = {r_instruction[31:12], 12'b0};

   // State register: reset drops any in-flight transaction by returning to
   // REQUEST, so a late memory response is simply ignored.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= REQUEST;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state and PC selection. A redirect beats every other event; if a
   // memory response is still owed we must drain it before fetching again.
   always_comb begin
      w_nextState   = r_state;
      w_nextPc      = r_pc;
      w_latchResp   = 1'b0;
      w_outstanding = 1'b0;
`ifdef JZJCOREF_MISALIGNED_TRAP_EN
      w_nextFault   = r_fault;
`endif
      if (redirectValid) begin
         w_nextPc = w_target;
         case (r_state)
            REQUEST:          w_outstanding = imemReqReady;
            WAIT_RESP, DRAIN: w_outstanding = !imemRespValid;
            default:          w_outstanding = 1'b0;
         endcase
`ifdef JZJCOREF_MISALIGNED_TRAP_EN
         w_nextFault = w_misaligned;
`endif
         if (w_outstanding) begin
            w_nextState = DRAIN;
`ifdef JZJCOREF_MISALIGNED_TRAP_EN
         end else if (w_misaligned) begin
            w_nextState = FAULT;
`endif
         end else begin
            w_nextState = REQUEST;
         end
      end else begin
         case (r_state)
            REQUEST: begin
               if (imemReqReady) begin
                  w_nextState = WAIT_RESP;
               end
            end
            WAIT_RESP: begin
               if (imemRespValid) begin
                  w_latchResp = 1'b1;
                  w_nextPc    = r_pc + 32'd4;
                  w_nextState = HOLD;
               end
            end
            HOLD: begin
               if (instrReady) begin
                  w_nextState = REQUEST;
               end
            end
            DRAIN: begin
               if (imemRespValid) begin
`ifdef JZJCOREF_MISALIGNED_TRAP_EN
                  w_nextState = r_fault ? FAULT : REQUEST;
`else
                  w_nextState = REQUEST;
`endif
               end
            end
`ifdef JZJCOREF_MISALIGNED_TRAP_EN
            FAULT: begin
               w_nextState = FAULT;
            end
`endif
            default: begin
               w_nextState = REQUEST;
            end
         endcase
      end
   end

   // PC and held-instruction registers; the held copy only changes when a
   // live (non-stale) response is accepted.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_pc              <= RESET_VECTOR;
         r_instruction     <= NOP;
         r_pcOfInstruction <= 32'h00000000;
      end else begin
         r_pc <= w_nextPc;
         if (w_latchResp) begin
            r_instruction     <= imemRespData;
            r_pcOfInstruction <= r_pc;
         end
      end
   end

`ifdef JZJCOREF_MISALIGNED_TRAP_EN
   // Trap flag: raised by a misaligned redirect (even while still draining),
   // cleared by reset or an aligned redirect.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_fault <= 1'b0;
      end else begin
         r_fault <= w_nextFault;
      end
   end
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: directed and randomized checks of the fetch unit
// against a program-order model (next PC to deliver) and a simple memory.
module tb_instruction_fetch_unit;

   localparam logic [31:0] RV = 32'h00000100;

   logic        clock;
   logic        reset;
   logic        imemReqValid;
   logic        imemReqReady;
   logic [31:0] imemAddress;
   logic        imemRespValid;
   logic [31:0] imemRespData;
   logic        instrValid;
   logic        instrReady;
   logic [31:0] instruction;
   logic [31:0] pcOfInstruction;
   logic [31:0] immediateU;
   logic        redirectValid;
   logic [31:0] redirectTarget;
   logic        fetchFault;

   int          total = 0;
   int          bad = 0;
   logic [31:0] modelPc;
   logic        modelFault;
   int          consumed;
   int          acceptCount;
   logic [31:0] lastAcceptAddr;
   logic        memBusy;
   int          memCount;
   logic [31:0] memAddr;
   int          fixedLat;
   logic        randomReady;
   logic        overrideEn;
   logic [31:0] overrideData;

   instruction_fetch_unit #(.RESET_VECTOR(RV)) dut (
      .clock(clock),
      .reset(reset),
      .imemReqValid(imemReqValid),
      .imemReqReady(imemReqReady),
      .imemAddress(imemAddress),
      .imemRespValid(imemRespValid),
      .imemRespData(imemRespData),
      .instrValid(instrValid),
      .instrReady(instrReady),
      .instruction(instruction),
      .pcOfInstruction(pcOfInstruction),
      .immediateU(immediateU),
      .redirectValid(redirectValid),
      .redirectTarget(redirectTarget),
      .fetchFault(fetchFault)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Run-away guard in case the design stalls forever.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: observed=running required=finished");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [31:0] memWord(input logic [31:0] a);
      if (a == 32'h00000100) return 32'h123450B7;
      return (a * 32'h0019660D) ^ 32'h3C6EF35F;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive memory, check against the model, advance.
   task automatic applyStimulus();
      logic        respNow;
      logic        accepted;
      logic [31:0] accAddr;
      logic [31:0] expInstr;
      respNow       = memBusy && (memCount == 0);
      imemRespValid = respNow;
      imemRespData  = respNow ? (overrideEn ? overrideData : memWord(memAddr)) : 32'h0;
      imemReqReady  = !memBusy && (randomReady ? ($urandom_range(0, 1) == 1) : 1'b1);
      #1;
      accepted = imemReqValid && imemReqReady;
      accAddr  = imemAddress;
      if (reset) begin
         checkOutput("reqInReset", 32'(imemReqValid), 32'h0);
      end else begin
         checkOutput("fetchFault", 32'(fetchFault), 32'(modelFault));
         if (modelFault) checkOutput("noReqInFault", 32'(imemReqValid), 32'h0);
         if (accepted) begin
            checkOutput("reqAddr", accAddr, modelPc);
            acceptCount++;
            lastAcceptAddr = accAddr;
         end
         if (instrValid) checkOutput("noReqInHold", 32'(imemReqValid), 32'h0);
         if (instrValid && instrReady) begin
            expInstr = memWord(modelPc);
            checkOutput("pcOfInstr", pcOfInstruction, modelPc);
            checkOutput("instr", instruction, expInstr);
            checkOutput("immU", immediateU, {expInstr[31:12], 12'h000});
            modelPc = modelPc + 32'd4;
            consumed++;
         end
         if (redirectValid) begin
`ifdef JZJCOREF_MISALIGNED_TRAP_EN
            modelFault = (redirectTarget[1:0] != 2'b00);
            modelPc    = redirectTarget;
`else
            modelPc    = {redirectTarget[31:2], 2'b00};
`endif
         end
      end
      @(posedge clock);
      #1;
      if (reset) begin
         modelPc    = RV;
         modelFault = 1'b0;
      end
      if (respNow) begin
         memBusy    = 1'b0;
         overrideEn = 1'b0;
      end else if (memBusy) begin
         memCount--;
      end
      if (accepted) begin
         memBusy  = 1'b1;
         memAddr  = accAddr;
         memCount = ((fixedLat > 0) ? fixedLat : int'($urandom_range(1, 3))) - 1;
      end
   endtask

   task automatic waitAccept(input string tag);
      int a;
      a = acceptCount;
      for (int n = 0; n < 30 && acceptCount == a; n++) applyStimulus();
      checkOutput(tag, 32'(acceptCount != a), 32'h1);
   endtask

   initial begin
      logic [31:0] savedInstr;
      logic [31:0] savedPc;
      logic [31:0] r;
      int          a;
      int          startConsumed;
      reset = 1'b1; instrReady = 1'b0; redirectValid = 1'b0; redirectTarget = 32'h0;
      imemReqReady = 1'b0; imemRespValid = 1'b0; imemRespData = 32'h0;
      modelPc = RV; modelFault = 1'b0; consumed = 0; acceptCount = 0; lastAcceptAddr = 32'h0;
      memBusy = 1'b0; memCount = 0; memAddr = 32'h0; fixedLat = 1; randomReady = 1'b0;
      overrideEn = 1'b0; overrideData = 32'h0;

      applyStimulus();
      applyStimulus();
      reset = 1'b0;
      #1;
      checkOutput("rst_instrValid", 32'(instrValid), 32'h0);
      checkOutput("rst_instr", instruction, 32'h00000013);
      checkOutput("rst_pcOf", pcOfInstruction, 32'h0);
      checkOutput("rst_immU", immediateU, 32'h0);
      checkOutput("rst_fault", 32'(fetchFault), 32'h0);
      checkOutput("rst_addr", imemAddress, RV);
      checkOutput("rst_reqValid", 32'(imemReqValid), 32'h1);

      $display("[TB] step 1: first fetch");
      instrReady = 1'b1;
      for (int n = 0; n < 10 && !instrValid; n++) applyStimulus();
      checkOutput("t1_valid", 32'(instrValid), 32'h1);
      checkOutput("t1_instr", instruction, 32'h123450B7);
      checkOutput("t1_pcOf", pcOfInstruction, 32'h00000100);
      checkOutput("t1_immU", immediateU, 32'h12345000);
      applyStimulus();
      waitAccept("t1_reqTimeout");
      checkOutput("t1_nextReq", lastAcceptAddr, 32'h00000104);

      $display("[TB] step 2: decode stall");
      instrReady = 1'b0;
      for (int n = 0; n < 10 && !instrValid; n++) applyStimulus();
      savedInstr = instruction;
      savedPc    = pcOfInstruction;
      for (int n = 0; n < 5; n++) begin
         applyStimulus();
         checkOutput("t2_valid", 32'(instrValid), 32'h1);
         checkOutput("t2_instr", instruction, savedInstr);
         checkOutput("t2_pcOf", pcOfInstruction, savedPc);
         checkOutput("t2_noReq", 32'(imemReqValid), 32'h0);
      end
      instrReady = 1'b1;
      applyStimulus();
      checkOutput("t2_dropped", 32'(instrValid), 32'h0);
      checkOutput("t2_req", 32'(imemReqValid), 32'h1);
      checkOutput("t2_reqAddr", imemAddress, savedPc + 32'd4);

      $display("[TB] step 3: redirect while waiting");
      fixedLat = 3;
      waitAccept("t3_reqTimeout");
      redirectValid = 1'b1; redirectTarget = 32'h00000200;
      overrideEn = 1'b1; overrideData = 32'hDEADBEEF;
      applyStimulus();
      redirectValid = 1'b0;
      a = acceptCount;
      for (int n = 0; n < 30 && acceptCount == a; n++) begin
         applyStimulus();
         if (instrValid) checkOutput("t3_noStale", 32'(instruction == 32'hDEADBEEF), 32'h0);
      end
      checkOutput("t3_nextReq", lastAcceptAddr, 32'h00000200);

      $display("[TB] step 4: redirect with response");
      fixedLat = 1;
      waitAccept("t4_reqTimeout");
      redirectValid = 1'b1; redirectTarget = 32'h00000300;
      applyStimulus();
      redirectValid = 1'b0;
      checkOutput("t4_req", 32'(imemReqValid), 32'h1);
      checkOutput("t4_addr", imemAddress, 32'h00000300);
      checkOutput("t4_noValid", 32'(instrValid), 32'h0);

      $display("[TB] step 5: pc wrap");
      redirectValid = 1'b1; redirectTarget = 32'hFFFFFFFC;
      applyStimulus();
      redirectValid = 1'b0;
      waitAccept("t5_reqTimeout");
      checkOutput("t5_req", lastAcceptAddr, 32'hFFFFFFFC);
      waitAccept("t5_wrapTimeout");
      checkOutput("t5_wrap", lastAcceptAddr, 32'h00000000);

      $display("[TB] step 6: misaligned redirect");
      redirectValid = 1'b1; redirectTarget = 32'h00000202;
      applyStimulus();
      redirectValid = 1'b0;
`ifdef JZJCOREF_MISALIGNED_TRAP_EN
      a = acceptCount;
      for (int n = 0; n < 10; n++) applyStimulus();
      checkOutput("t6_fault", 32'(fetchFault), 32'h1);
      checkOutput("t6_noReq", 32'(acceptCount - a), 32'h0);
      redirectValid = 1'b1; redirectTarget = 32'h00000204;
      applyStimulus();
      redirectValid = 1'b0;
      checkOutput("t6_clear", 32'(fetchFault), 32'h0);
      waitAccept("t6_reqTimeout");
      checkOutput("t6_req", lastAcceptAddr, 32'h00000204);
`else
      waitAccept("t6_reqTimeout");
      checkOutput("t6_aligned", lastAcceptAddr, 32'h00000200);
`endif

      $display("[TB] step 7: randomized traffic");
      randomReady = 1'b1;
      fixedLat = 0;
      startConsumed = consumed;
      for (int i = 0; i < 600; i++) begin
         reset = (i == 300);
         instrReady = ($urandom_range(0, 1) == 1);
         redirectValid = !reset && ($urandom_range(0, 15) == 0);
         r = $urandom();
`ifdef JZJCOREF_MISALIGNED_TRAP_EN
         r[1:0] = 2'b00;
`endif
         redirectTarget = r;
         applyStimulus();
      end
      reset = 1'b0;
      redirectValid = 1'b0;
      checkOutput("rand_progress", 32'((consumed - startConsumed) >= 20), 32'h1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
